// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields plus a signed immediate into an instruction word,
// with format range checks, a one-stage valid/ready output register and an address counter.
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    input  logic             addr_load,
    input  logic [31:0]      addr_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_addr,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);
    localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
                           FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5;

    logic signed [31:0] simm;
    logic [31:0] word;
    logic [31:0] cnt;
    logic legal;
    logic accept;

    assign simm     = in_imm;
    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        legal = (in_fmt == FMT_R) ? 1'b1 :
                (in_fmt == FMT_I || in_fmt == FMT_S) ? (simm >= -32'sd2048 && simm <= 32'sd2047) :
                (in_fmt == FMT_B) ? (simm >= -32'sd4096 && simm <= 32'sd4094 && !in_imm[0]) :
                (in_fmt == FMT_J) ? (simm >= -32'sd1048576 && simm <= 32'sd1048574 && !in_imm[0]) :
                (in_fmt == FMT_U) ? (in_imm[11:0] == 12'd0) : 1'b0;
        word  = (in_fmt == FMT_R) ? {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode} :
                (in_fmt == FMT_I) ? {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode} :
                (in_fmt == FMT_S) ? {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode} :
                (in_fmt == FMT_B) ? {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                     in_imm[4:1], in_imm[11], in_opcode} :
                (in_fmt == FMT_U) ? {in_imm[31:12], in_rd, in_opcode} :
                {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
    end

    // cnt always holds the address the next emitted word will carry
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_inst  <= 32'd0;
            out_addr  <= BASE_ADDR;
            cnt       <= BASE_ADDR;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            err <= accept && !legal;
            if (accept && !legal && !(&err_count))
                err_count <= err_count + ERR_W'(1);
            if (accept && legal) begin
                out_valid <= 1'b1;
                out_inst  <= word;
                out_addr  <= cnt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (addr_load)
                cnt <= addr_val;
            else if (accept && legal)
                cnt <= cnt + 32'd4;
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: table-driven vectors for the encoder plus directed sequences for
// backpressure, error saturation, address loading/wrap and reset mid-transfer.
module tb_inst_encoder;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, addr_load, out_valid, out_ready, err;
    logic [2:0]  in_fmt, in_funct3;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, addr_val, out_inst, out_addr;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ok;
        logic [31:0] inst;
    } vec_t;

    vec_t v[23];

    inst_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .addr_load(addr_load), .addr_val(addr_val), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
        .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        in_fmt = x.fmt; in_opcode = x.op; in_rd = x.rd; in_rs1 = x.rs1;
        in_rs2 = x.rs2; in_funct3 = x.f3; in_funct7 = x.f7; in_imm = x.imm;
    endtask

    initial begin
        logic [31:0] ea;
        int ecnt;
        vec_t a, b;
        v[0]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        1'b1, 32'h00500093};
        v[1]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        1'b1, 32'h0020A423};
        v[2]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3};
        v[3]  = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     1'b1, 32'h001000EF};
        v[4]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b1, 32'h123452B7};
        v[5]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     1'b0, 32'h0};
        v[6]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd6,        1'b1, 32'h00208363};
        v[7]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd5,        1'b0, 32'h0};
        v[8]  = '{3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,        1'b0, 32'h0};
        v[9]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, 1'b1, 32'h402081B3};
        v[10] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 1'b1, 32'h80000093};
        v[11] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2047,     1'b1, 32'h7FF00093};
        v[12] = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd2047,     1'b1, 32'h7E20AFA3};
        v[13] = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFFF7FF, 1'b0, 32'h0};
        v[14] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,     1'b1, 32'h7E000FE3};
        v[15] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,     1'b0, 32'h0};
        v[16] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF000, 1'b1, 32'h80000063};
        v[17] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00000, 1'b1, 32'h8000006F};
        v[18] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1048576,  1'b0, 32'h0};
        v[19] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,        1'b0, 32'h0};
        v[20] = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 1'b0, 32'h0};
        v[21] = '{3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,        1'b0, 32'h0};
        v[22] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1048574,  1'b1, 32'h7FFFF06F};
        a = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1, 1'b1, 32'h00100093};
        b = '{3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2, 1'b1, 32'h00200113};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; addr_load = 1'b0; addr_val = 32'd0;
        drive(a);
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        ea = 32'd0;
        ecnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 23; i++) begin
            drive(v[i]);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            if (v[i].ok) begin
                chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
                chk($sformatf("vec%0d_inst", i), out_inst, v[i].inst);
                chk($sformatf("vec%0d_addr", i), out_addr, ea);
                ea += 32'd4;
            end else begin
                chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd0);
                ecnt++;
            end
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(!v[i].ok));
            chk($sformatf("vec%0d_err_count", i), 32'(err_count), 32'(ecnt));
        end
        step();
        chk("post_vec_err", 32'(err), 32'd0);
        chk("post_vec_valid", 32'(out_valid), 32'd0);

        in_fmt = 3'd7;
        in_valid = 1'b1;
        repeat (300) step();
        in_valid = 1'b0;
        step();
        chk("sat_err_count", 32'(err_count), 32'd255);
        chk("sat_err_low", 32'(err), 32'd0);
        chk("sat_no_output", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        drive(a);
        in_valid = 1'b1;
        step();
        drive(b);
        step(); step();
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_inst_held", out_inst, a.inst);
        chk("bp_addr_held", out_addr, ea);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_up", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_second_inst", out_inst, b.inst);
        chk("bp_second_addr", out_addr, ea + 32'd4);
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);
        ea += 32'd8;

        out_ready = 1'b0;
        drive(a);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        addr_load = 1'b1;
        addr_val = 32'h0000_0100;
        step();
        addr_load = 1'b0;
        chk("ld_held_addr", out_addr, ea);
        chk("ld_held_inst", out_inst, a.inst);
        out_ready = 1'b1;
        drive(b);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("ld_new_addr", out_addr, 32'h0000_0100);
        chk("ld_new_inst", out_inst, b.inst);
        step();

        addr_load = 1'b1;
        addr_val = 32'hFFFF_FFFC;
        step();
        addr_load = 1'b0;
        drive(a);
        in_valid = 1'b1;
        step();
        chk("wrap_first_addr", out_addr, 32'hFFFF_FFFC);
        drive(b);
        step();
        in_valid = 1'b0;
        chk("wrap_second_addr", out_addr, 32'h0000_0000);
        chk("wrap_second_inst", out_inst, b.inst);
        step();

        out_ready = 1'b0;
        drive(a);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("mid_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_addr", out_addr, 32'd0);
        chk("mid_rst_err_count", 32'(err_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the core's immediate generator: packs decoded instruction fields plus a 32-bit signed immediate into a 32-bit RV32I instruction word.
- Used by the test/boot path to stream generated programs into instruction memory.
- Valid/ready input and output. One-stage registered pipeline with an address counter.
- Range and alignment checks per format, with error reporting.

Parameters:
- BASE_ADDR, 32'h0000_0000, reset/initial value of the output address counter.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input fields valid
- in_ready  out  1  block can accept input this cycle
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal
- in_opcode  in  7  opcode field, placed in inst[6:0] unchanged
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field (R only)
- in_imm  in  32  signed byte-offset immediate (U: full upper value)
- addr_load  in  1  load address counter
- addr_val  in  32  value loaded on addr_load, word-aligned
- out_valid  out  1  out_inst/out_addr valid
- out_ready  in  1  downstream accepts
- out_inst  out  32  encoded instruction
- out_addr  out  32  address of out_inst
- err  out  1  one-cycle pulse, input rejected
- err_count  out  ERR_W  saturating count of rejected inputs

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_inst=0, out_addr=BASE_ADDR, err=0, err_count=0.
  - in_ready is forced 0 while rst is high.
  - Reset mid-transfer drops any held output.
- in_ready = !out_valid || out_ready. It is combinational and does not depend on in_valid.
- An input is accepted when in_valid && in_ready.
- Legal accepted input: next cycle out_valid=1 and out_inst = packed word. Latency is 1 cycle.
- out_valid/out_inst/out_addr are held stable until out_valid && out_ready.
- A new accept in the same cycle as an output handshake gives back-to-back issue, so full throughput is possible.
- Packing (bits high to low):
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
- Fields not used by a format are ignored.
- Checks (imm treated as signed):
  - I, S: imm must be in [-2048, 2047].
  - B: imm must be in [-4096, 4094] and imm[0]=0.
  - J: imm must be in [-1048576, 1048574] and imm[0]=0.
  - U: imm[11:0] must be 0.
  - R: no immediate check.
  - fmt 6 or 7: always illegal.
- Illegal accepted input:
  - err=1 for the next cycle only; err_count increments and saturates at all-ones.
  - out_valid and out_addr are unchanged; nothing is emitted.
  - in_ready behaves normally.
- Address counter:
  - out_addr advances by 4 on each output handshake, with 32-bit wrap (32'hFFFF_FFFC -> 0).
  - Attached address = counter value at emission.
- addr_load:
  - Sets the counter to addr_val. Takes effect on the next word emitted.
  - If a word is currently held (out_valid=1 and not yet handed off), its out_addr is not changed.
  - If addr_load coincides with an output handshake, addr_load wins and the +4 is discarded.
- rst has priority over all other inputs.

Test Plan:
- Reset, then I-type: opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 -> next cycle out_valid=1, out_inst=0x00500093, out_addr=0x0.
- S-type with out_ready=1: opcode 0x23, rs1=1, rs2=2, funct3=2, imm=8 -> out_inst=0x0020A423, out_addr=0x4.
- B-type: opcode 0x63, rs1=1, rs2=2, funct3=0, imm=-4 -> 0xFE208EE3.
  - J-type: opcode 0x6F, rd=1, imm=2048 -> 0x001000EF.
  - U-type: opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7.
- Errors:
  - I-type imm=2048 -> err pulses 1 cycle, err_count=1, no output, address unchanged.
  - B-type imm=6 (legal range, imm[0]=0) is accepted; imm=5 -> err.
  - fmt=7 -> err.
  - 300 illegal inputs -> err_count=255.
- Backpressure:
  - Hold out_ready=0 with 2 inputs queued -> first word held stable, in_ready=0, second input not accepted.
  - Raise out_ready -> words emitted in order at consecutive addresses.
- Counter edge cases:
  - addr_load with addr_val=0xFFFFFFFC, then 2 instructions -> out_addr 0xFFFFFFFC, then 0x0.
  - Assert rst while out_valid=1 -> out_valid=0, out_addr=BASE_ADDR next cycle.
